// File: rtl/affine_scan_pkg.sv
// Shared types for the 2D affine address sequencer.
// Holds default widths, the FSM state and the scan descriptor bundle.
package affine_scan_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] offset;
    logic [ADDR_W_DEF-1:0] x_stride;
    logic [ADDR_W_DEF-1:0] y_stride;
    logic [CNT_W_DEF-1:0]  x_max;
    logic [CNT_W_DEF-1:0]  y_max;
  } scan_cfg_t;

endpackage

// File: rtl/scan_counter2d.sv
// x/y position counters for one scan job (x fastest).
// Ports: load restarts at (0,0); step advances one beat; x_max/y_max
// are extents; first = column 0, row_end = last column, last = final
// beat of the job; last_nxt = the position after this cycle is final.
module scan_counter2d #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] x_max,
  input  logic [CNT_W-1:0] y_max,
  output logic             first,
  output logic             row_end,
  output logic             last,
  output logic             last_nxt
);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] x_lim;
  logic [CNT_W-1:0] y_lim;

  assign x_lim   = x_max - CNT_W'(1);
  assign y_lim   = y_max - CNT_W'(1);
  assign first   = (x_q == '0);
  assign row_end = (x_q == x_lim);
  assign last    = row_end && (y_q == y_lim);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (row_end) begin
        x_d = '0;
        y_d = y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  assign last_nxt = (x_d == x_lim) && (y_d == y_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/affine_scan_ctrl.sv
// Bounded, flow-controlled 2D affine address sequencer.
// Ports: cfg_* descriptor in (valid/ready), abort, addr/addr_last out
// (valid/ready), done pulse after the final beat, busy while running.
import affine_scan_pkg::*;

module affine_scan_ctrl #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic [ADDR_W-1:0] cfg_x_stride,
  input  logic [ADDR_W-1:0] cfg_y_stride,
  input  logic [CNT_W-1:0]  cfg_x_max,
  input  logic [CNT_W-1:0]  cfg_y_max,
  input  logic              abort,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              done,
  output logic              busy
);

  state_t            state_q, state_d;
  scan_cfg_t         cfg_q, cfg_d, cfg_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              addr_valid_q, addr_valid_d;
  logic              addr_last_q, addr_last_d;
  logic              done_q, done_d;

  logic              zero_ext;
  logic              load;
  logic              fire;
  logic              step;
  logic              cnt_first;
  logic              cnt_row_end;
  logic              cnt_last;
  logic              cnt_last_nxt;
  logic [ADDR_W-1:0] x_stride;
  logic [ADDR_W-1:0] y_stride;

  assign cfg_in.offset   = ADDR_W_DEF'(cfg_offset);
  assign cfg_in.x_stride = ADDR_W_DEF'(cfg_x_stride);
  assign cfg_in.y_stride = ADDR_W_DEF'(cfg_y_stride);
  assign cfg_in.x_max    = CNT_W_DEF'(cfg_x_max);
  assign cfg_in.y_max    = CNT_W_DEF'(cfg_y_max);

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);

  assign zero_ext = (cfg_x_max == '0) || (cfg_y_max == '0);
  assign load     = cfg_ready && cfg_valid && !zero_ext;
  assign fire     = busy && addr_valid_q && addr_ready;
  // Abort swallows the beat, so the counters need not move.
  assign step     = fire && !abort && !cnt_last;

  // Descriptor view: fresh inputs while loading, latched copy otherwise.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_ready && cfg_valid) begin
      cfg_d = cfg_in;
    end
  end

  assign x_stride = ADDR_W'(cfg_q.x_stride);
  assign y_stride = ADDR_W'(cfg_q.y_stride);

  scan_counter2d #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .x_max    (CNT_W'(cfg_d.x_max)),
    .y_max    (CNT_W'(cfg_d.y_max)),
    .first    (cnt_first),
    .row_end  (cnt_row_end),
    .last     (cnt_last),
    .last_nxt (cnt_last_nxt)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_base_d   = row_base_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (zero_ext) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            addr_d       = ADDR_W'(cfg_d.offset);
            row_base_d   = ADDR_W'(cfg_d.offset);
            addr_valid_d = 1'b1;
            addr_last_d  = cnt_last_nxt;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d      = IDLE;
          addr_valid_d = 1'b0;
          addr_last_d  = 1'b0;
        end else if (fire) begin
          if (cnt_last) begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
            done_d       = 1'b1;
          end else if (cnt_row_end) begin
            addr_d      = row_base_q + y_stride;
            row_base_d  = row_base_q + y_stride;
            addr_last_d = cnt_last_nxt;
          end else begin
            addr_d      = addr_q + x_stride;
            // Column 0 of a row is its base; keeps row_base in step.
            if (cnt_first) begin
              row_base_d = addr_q;
            end
            addr_last_d = cnt_last_nxt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      addr_q       <= '0;
      row_base_q   <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      done_q       <= done_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_affine_scan_ctrl.sv
// Directed bench for affine_scan_ctrl.
// Linear sequence of jobs with hand-computed address streams.
module tb_affine_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_offset;
  logic [31:0] cfg_x_stride;
  logic [31:0] cfg_y_stride;
  logic [31:0] cfg_x_max;
  logic [31:0] cfg_y_max;
  logic        abort;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic        addr_last;
  logic        done;
  logic        busy;

  int n_run;
  int n_fail;

  logic [31:0] e1 [6];

  affine_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_offset   (cfg_offset),
    .cfg_x_stride (cfg_x_stride),
    .cfg_y_stride (cfg_y_stride),
    .cfg_x_max    (cfg_x_max),
    .cfg_y_max    (cfg_y_max),
    .abort        (abort),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] off, input logic [31:0] xs,
                         input logic [31:0] ys, input logic [31:0] xm,
                         input logic [31:0] ym);
    cfg_valid    = 1'b1;
    cfg_offset   = off;
    cfg_x_stride = xs;
    cfg_y_stride = ys;
    cfg_x_max    = xm;
    cfg_y_max    = ym;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    e1 = '{32'd100, 32'd104, 32'd108, 32'd164, 32'd168, 32'd172};
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_offset = '0;
    cfg_x_stride = '0;
    cfg_y_stride = '0;
    cfg_x_max = '0;
    cfg_y_max = '0;
    abort = 1'b0;
    addr_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_last", {31'd0, addr_last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Basic 3x2 job
    set_cfg(32'd100, 32'd4, 32'd64, 32'd3, 32'd2);
    addr_ready = 1'b1;
    chk("t1_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_valid", {31'd0, addr_valid}, 32'd1);
      chk("t1_addr", addr, e1[i]);
      chk("t1_last", {31'd0, addr_last}, (i == 5) ? 32'd1 : 32'd0);
      chk("t1_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_valid_end", {31'd0, addr_valid}, 32'd0);
    chk("t1_cfg_ready_end", {31'd0, cfg_ready}, 32'd1);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure on 104
    set_cfg(32'd100, 32'd4, 32'd64, 32'd3, 32'd2);
    tick();
    cfg_valid = 1'b0;
    chk("t2_addr0", addr, 32'd100);
    tick();
    chk("t2_addr1", addr, 32'd104);
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_addr", addr, 32'd104);
      chk("t2_hold_valid", {31'd0, addr_valid}, 32'd1);
      chk("t2_hold_last", {31'd0, addr_last}, 32'd0);
    end
    addr_ready = 1'b1;
    tick();
    chk("t2_addr2", addr, 32'd108);
    tick();
    chk("t2_addr3", addr, 32'd164);
    tick();
    chk("t2_addr4", addr, 32'd168);
    tick();
    chk("t2_addr5", addr, 32'd172);
    chk("t2_last5", {31'd0, addr_last}, 32'd1);
    tick();
    chk("t2_done", {31'd0, done}, 32'd1);

    // Zero extent
    set_cfg(32'd7, 32'd1, 32'd1, 32'd0, 32'd5);
    tick();
    cfg_valid = 1'b0;
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_valid", {31'd0, addr_valid}, 32'd0);
    chk("t3_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_done_pulse", {31'd0, done}, 32'd0);
    chk("t3_valid2", {31'd0, addr_valid}, 32'd0);

    // Address wrap-around
    set_cfg(32'hFFFF_FFFC, 32'd4, 32'd0, 32'd2, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t4_addr0", addr, 32'hFFFF_FFFC);
    chk("t4_last0", {31'd0, addr_last}, 32'd0);
    tick();
    chk("t4_addr1", addr, 32'h0000_0000);
    chk("t4_last1", {31'd0, addr_last}, 32'd1);
    tick();
    chk("t4_done", {31'd0, done}, 32'd1);

    // Single-column job: every beat is a row advance
    set_cfg(32'd10, 32'd3, 32'd7, 32'd1, 32'd3);
    tick();
    cfg_valid = 1'b0;
    chk("t5_addr0", addr, 32'd10);
    chk("t5_last0", {31'd0, addr_last}, 32'd0);
    tick();
    chk("t5_addr1", addr, 32'd17);
    tick();
    chk("t5_addr2", addr, 32'd24);
    chk("t5_last2", {31'd0, addr_last}, 32'd1);
    tick();
    chk("t5_done", {31'd0, done}, 32'd1);

    // Abort, ignored cfg during RUN, back-to-back restart
    set_cfg(32'd0, 32'd1, 32'd16, 32'd4, 32'd4);
    tick();
    set_cfg(32'd500, 32'd1, 32'd0, 32'd2, 32'd1);
    chk("t6_addr0", addr, 32'd0);
    chk("t6_cfg_ready_run", {31'd0, cfg_ready}, 32'd0);
    tick();
    chk("t6_addr1", addr, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_valid", {31'd0, addr_valid}, 32'd0);
    chk("t6_abort_done", {31'd0, done}, 32'd0);
    chk("t6_abort_busy", {31'd0, busy}, 32'd0);
    chk("t6_abort_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t6_new_addr0", addr, 32'd500);
    chk("t6_new_valid", {31'd0, addr_valid}, 32'd1);
    chk("t6_new_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("t6_new_addr1", addr, 32'd501);
    chk("t6_new_last", {31'd0, addr_last}, 32'd1);
    tick();
    chk("t6_new_done", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-job
    set_cfg(32'd200, 32'd1, 32'd0, 32'd3, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t7_addr0", addr, 32'd200);
    #3;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_done", {31'd0, done}, 32'd0);
    chk("t7_rst_addr", addr, 32'd0);
    chk("t7_rst_ready", {31'd0, cfg_ready}, 32'd1);
    #2;
    rst = 1'b0;
    tick();
    chk("t7_idle_done", {31'd0, done}, 32'd0);
    set_cfg(32'd300, 32'd1, 32'd0, 32'd1, 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t7_new_addr", addr, 32'd300);
    chk("t7_new_last", {31'd0, addr_last}, 32'd1);
    chk("t7_new_valid", {31'd0, addr_valid}, 32'd1);
    tick();
    chk("t7_new_done", {31'd0, done}, 32'd1);
    chk("t7_new_end", {31'd0, addr_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
